// File: rtl/javk_biu.sv
// JAVK bus interface unit: turns core read/write/burst requests into sequenced
// ADDR / WAIT / DATA bus cycles on a shared tristate data bus.
module javk_biu #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_MAX   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [$clog2(BURST_MAX)-1:0] req_len,
  output logic                         req_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         done,
  input  logic                         mem_rdy,
  inout  wire  [DATA_W-1:0]            databus,
  output logic [ADDR_W-1:0]            addrbus,
  output logic                         rw
);

  localparam int         LEN_W     = $clog2(BURST_MAX);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA
  } state_t;

  state_t             state, state_d;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [LEN_W-1:0]   beats_q;   // beats remaining after the current one
  logic [3:0]         wait_cnt;
  logic               accept;
  logic               beat_end;
  logic               last_beat;

  assign last_beat = (beats_q == '0);
  assign req_ready = (state == S_IDLE) && !rst;

  // The write data owns the bus for the whole bus cycle, from ADDR to the final DATA edge.
  assign databus = (we_q && (state != S_IDLE)) ? wdata_q : 'z;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    beat_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = HAS_WAIT ? S_WAIT : S_DATA;
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_d = S_DATA;
      end
      S_DATA: begin
        if (mem_rdy) begin
          beat_end = 1'b1;
          state_d  = last_beat ? S_IDLE : S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      wdata_q  <= '0;
      beats_q  <= '0;
      wait_cnt <= 4'd0;
      addrbus  <= '0;
      rw       <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;

      if (accept) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
        beats_q <= req_we ? '0 : req_len;
        addrbus <= req_addr;
        rw      <= !req_we;
      end

      if (state == S_ADDR)
        wait_cnt <= WAIT_LOAD;
      else if ((state == S_WAIT) && (wait_cnt != 4'd0))
        wait_cnt <= wait_cnt - 4'd1;

      if (beat_end) begin
        if (!we_q) begin
          rd_data  <= databus;
          rd_valid <= 1'b1;
        end
        if (last_beat) begin
          done <= 1'b1;
          rw   <= 1'b1;
        end else begin
          // Burst addresses wrap naturally at the top of the address space.
          addrbus <= addrbus + ADDR_W'(1);
          beats_q <= beats_q - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_javk_biu.sv
// Scoreboard bench for javk_biu: a cycle-schedule reference model, a ROM-like
// memory on the tristate bus and a monitor comparing every cycle and event.
module tb_javk_biu;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int W  = 1;
  localparam int BM = 4;
  localparam int LW = $clog2(BM);

  logic          clk;
  logic          rst;
  logic          req;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          req_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          mem_rdy;
  wire  [DW-1:0] databus;
  logic [AW-1:0] addrbus;
  logic          rw;

  logic          tb_drive;
  logic [DW-1:0] tb_val;
  assign databus = tb_drive ? tb_val : 'z;

  javk_biu #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len), .req_ready(req_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .mem_rdy(mem_rdy),
    .databus(databus), .addrbus(addrbus), .rw(rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: expected bus per cycle, mem_rdy plan, and event queues.
  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic          we;
    logic [DW-1:0] wdata;
  } bus_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } ev_t;

  bus_t          bus_exp[int];
  bit            rdy_map[int];
  ev_t           rd_q[$];
  int            done_q[$];
  logic [DW-1:0] mem [0:65535];
  logic [AW-1:0] idle_addr = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory/bus environment: answers reads from mem, and drives a probe value
  // whenever the unit should have released the bus.
  always @(posedge clk) begin
    #1;
    if (bus_exp.exists(cyc)) begin
      tb_drive = !bus_exp[cyc].we;
      tb_val   = mem[addrbus];
    end else begin
      tb_drive = 1'b1;
      tb_val   = DW'($urandom);
    end
    mem_rdy = rdy_map.exists(cyc) ? rdy_map[cyc] : 1'($urandom);
  end

  // Monitor: compares bus state every cycle and pops expected events.
  always @(negedge clk) begin
    int   c;
    bus_t e;
    ev_t  ev;
    int   dc;
    c = cyc;
    if (rst) begin
      check("ready_in_reset", 32'(req_ready), 32'd0);
      idle_addr = '0;
    end else if (bus_exp.exists(c)) begin
      e = bus_exp[c];
      check("addrbus", 32'(addrbus), 32'(e.addr));
      check("rw", 32'(rw), 32'(e.rw));
      check("ready_busy", 32'(req_ready), 32'd0);
      if (e.we) check("databus_wdata", 32'(databus), 32'(e.wdata));
      idle_addr = e.addr;
    end else begin
      check("addrbus_idle", 32'(addrbus), 32'(idle_addr));
      check("rw_idle", 32'(rw), 32'd1);
      check("ready_idle", 32'(req_ready), 32'd1);
      check("databus_released", 32'(databus), 32'(tb_val));
    end

    while (rd_q.size() > 0 && rd_q[0].cyc < c) begin
      check("rd_valid_missing_at", 32'(c), 32'(rd_q[0].cyc));
      void'(rd_q.pop_front());
    end
    while (done_q.size() > 0 && done_q[0] < c) begin
      check("done_missing_at", 32'(c), 32'(done_q[0]));
      void'(done_q.pop_front());
    end
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      else begin
        ev = rd_q.pop_front();
        check("rd_valid_cycle", 32'(c), 32'(ev.cyc));
        check("rd_data", 32'(rd_data), 32'(ev.data));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else begin
        dc = done_q.pop_front();
        check("done_cycle", 32'(c), 32'(dc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_req();
    req       = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_len   = LW'($urandom);
  endtask

  // Issue one transaction; the expected cycle schedule follows from beat =
  // ADDR(1) + WAIT(W) + DATA(1 + stalls), events one cycle after the last DATA cycle.
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int len, input int s_lo, input int s_hi, input int gap,
                       input bit abort);
    int   waited = 0;
    int   acc;
    int   t;
    int   s;
    int   n;
    int   ev;
    bus_t e;
    while (rst || !req_ready) begin
      junk_req();
      tick();
      waited++;
      if (waited > 500) begin
        check("ready_timeout", 32'(req_ready), 32'd1);
        return;
      end
    end
    for (int g = 0; g < gap; g++) begin
      req = 1'b0;
      tick();
    end
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_len = LW'(len);
    acc     = cyc;
    e.rw    = !we;
    e.we    = we;
    e.wdata = wd;
    t       = acc + 1;
    if (abort) begin
      e.addr = addr;
      for (int c = t; c <= t + W; c++) bus_exp[c] = e;
    end else begin
      n = we ? 1 : len + 1;
      for (int k = 0; k < n; k++) begin
        e.addr = addr + AW'(k);
        s      = $urandom_range(s_hi, s_lo);
        for (int c = t; c <= t + W + 1 + s; c++) bus_exp[c] = e;
        for (int c = t + W + 1; c <= t + W + 1 + s; c++) rdy_map[c] = (c == t + W + 1 + s);
        ev = t + W + 2 + s;
        if (!we) rd_q.push_back('{ev, mem[e.addr]});
        t = ev;
      end
      done_q.push_back(t);
    end
    tick();
    req = 1'b0;
    if (abort) begin
      repeat (W) begin
        junk_req();
        tick();
      end
      rst = 1'b1;
      req = 1'b0;
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit            we;
    logic [AW-1:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    mem[16'h1234] = 8'h5A;
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    tb_drive = 1'b0; tb_val = '0; mem_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    issue(1'b0, 16'h1234, 8'h00, 0, 0, 0, 1, 1'b0);  // single read, 0x5A expected
    issue(1'b1, 16'h00FF, 8'hC3, 0, 0, 0, 1, 1'b0);  // single write
    issue(1'b0, 16'hFFFE, 8'h00, 3, 0, 0, 1, 1'b0);  // 4-beat burst across the wrap
    issue(1'b0, 16'h0042, 8'h00, 0, 3, 3, 1, 1'b0);  // three mem_rdy stalls
    issue(1'b0, 16'h1000, 8'h00, 1, 0, 0, 1, 1'b0);  // back-to-back pair
    issue(1'b0, 16'h2000, 8'h00, 0, 0, 0, 0, 1'b0);
    issue(1'b1, 16'h3333, 8'h96, 0, 0, 0, 1, 1'b1);  // write aborted by reset in WAIT
    issue(1'b0, 16'h4444, 8'h00, 0, 0, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      we = ($urandom_range(2, 0) == 0);
      a  = ($urandom_range(3, 0) == 0) ? AW'(16'hFFFD + $urandom_range(2, 0)) : AW'($urandom);
      issue(we, a, DW'($urandom), $urandom_range(BM - 1, 0), 0, 2, $urandom_range(2, 0), 1'b0);
    end

    req = 1'b0;
    repeat (30) tick();
    check("rd_pending", 32'(rd_q.size()), 32'd0);
    check("done_pending", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
